reg_write_arbiter: RTL and testbench

- Shares the single write path of the CPU register bank among several requesters (e.g. ALU writeback, load unit, PC/link update, debug port).
- Arbitrates write requests round-robin and drives a one-hot clock_en vector plus a shared data bus into the bank's Register instances.
- Returns a one-cycle ack to the winning requester.
- Outputs are registered, so the bank captures the write one edge after the ack appears.

---
 rtl/reg_write_arbiter.sv | 80 ++++++++
 tb/tb_reg_write_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among NumReq requesters.
// Registered outputs: ack, one-hot reg_en and reg_data appear one edge after the request is seen.
module reg_write_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 16,
    parameter int NumRegs   = 8,
    parameter int AddrWidth = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NumReq-1:0]             req,
    input  logic [NumReq*AddrWidth-1:0]   req_addr,
    input  logic [NumReq*DataWidth-1:0]   req_data,
    output logic [NumReq-1:0]             ack,
    output logic [NumRegs-1:0]            reg_en,
    output logic [DataWidth-1:0]          reg_data,
    output logic                          addr_err,
    output logic                          busy
);

    localparam int PtrW = $clog2(NumReq);

    logic [PtrW-1:0]      ptr;
    logic [NumReq-1:0]    eligible_p0;
    logic                 found_p0;
    logic [PtrW-1:0]      win_p0;
    logic [AddrWidth-1:0] win_addr_p0;
    logic [DataWidth-1:0] win_data_p0;
    logic                 addr_ok_p0;

    function automatic logic [PtrW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NumReq) s = s - NumReq;
        return PtrW'(s);
    endfunction

    // A requester acked this cycle is masked so a still-held req cannot be granted twice in a row.
    assign eligible_p0 = req & ~ack;

    always_comb begin
        found_p0 = 1'b0;
        win_p0   = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found_p0 && eligible_p0[wrap_idx(int'(ptr), i)]) begin
                found_p0 = 1'b1;
                win_p0   = wrap_idx(int'(ptr), i);
            end
        end
    end

    assign win_addr_p0 = req_addr[win_p0*AddrWidth +: AddrWidth];
    assign win_data_p0 = req_data[win_p0*DataWidth +: DataWidth];
    assign addr_ok_p0  = {{(32-AddrWidth){1'b0}}, win_addr_p0} < 32'(NumRegs);

    // Stage boundary: grant, bank enable and data registered together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            ack      <= '0;
            reg_en   <= '0;
            reg_data <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
        end else if (found_p0) begin
            ptr      <= wrap_idx(int'(win_p0), 1);
            ack      <= NumReq'(1) << win_p0;
            reg_data <= win_data_p0;
            reg_en   <= addr_ok_p0 ? (NumRegs'(1) << win_addr_p0) : '0;
            addr_err <= !addr_ok_p0;
            busy     <= 1'b1;
        end else begin
            ack      <= '0;
            reg_en   <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NumReq=4, DataWidth=16, NumRegs=6, AddrWidth=3)
// with a small behavioural register bank driven by reg_en/reg_data.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int NG = 6;
    localparam int AW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     ack;
    logic [NG-1:0]     reg_en;
    logic [DW-1:0]     reg_data;
    logic              addr_err;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] bank [0:NG-1] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    reg_write_arbiter #(.NumReq(NR), .DataWidth(DW), .NumRegs(NG), .AddrWidth(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_data (reg_data),
        .addr_err (addr_err),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int k = 0; k < NG; k++)
            if (reg_en[k]) bank[k] <= reg_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic on, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = on;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();
        check("rst_ack",  32'(ack), 32'h0);
        check("rst_en",   32'(reg_en), 32'h0);
        check("rst_data", 32'(reg_data), 32'h0);
        check("rst_err",  32'(addr_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();

        // Single request from requester 0 to reg 5
        set_req(0, 1'b1, 3'd5, 16'hBEEF);
        tick();
        check("single_ack",  32'(ack), 32'h1);
        check("single_en",   32'(reg_en), 32'h20);
        check("single_data", 32'(reg_data), 32'hBEEF);
        check("single_busy", 32'(busy), 32'h1);
        check("single_err",  32'(addr_err), 32'h0);
        tick();
        check("single_noregrant_ack", 32'(ack), 32'h0);
        check("single_noregrant_en",  32'(reg_en), 32'h0);
        check("single_idle_busy",     32'(busy), 32'h0);
        check("single_bank5",         32'(bank[5]), 32'hBEEF);
        set_req(0, 1'b0, 3'd0, 16'h0);
        tick();
        check("idle_data_hold", 32'(reg_data), 32'hBEEF);

        // Reset mid-grant: requester 2 to reg 3, ptr would otherwise favour requester 3
        set_req(2, 1'b1, 3'd3, 16'h1234);
        tick();
        check("mid_ack", 32'(ack), 32'h4);
        check("mid_en",  32'(reg_en), 32'h8);
        #2;
        reset = 1'b1;
        #1;
        check("async_ack",  32'(ack), 32'h0);
        check("async_en",   32'(reg_en), 32'h0);
        check("async_data", 32'(reg_data), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        set_req(0, 1'b1, 3'd0, 16'hA000);
        set_req(1, 1'b1, 3'd1, 16'hA001);
        set_req(2, 1'b1, 3'd2, 16'hA002);
        set_req(3, 1'b1, 3'd4, 16'hA003);
        tick();
        check("rst_nowrite_bank3", 32'(bank[3]), 32'h0);
        reset = 1'b0;

        // Full contention after reset: grants 0,1,2,3,0,1
        tick();
        check("fc0_ack", 32'(ack), 32'h1);  check("fc0_en", 32'(reg_en), 32'h01); check("fc0_data", 32'(reg_data), 32'hA000);
        tick();
        check("fc1_ack", 32'(ack), 32'h2);  check("fc1_en", 32'(reg_en), 32'h02); check("fc1_data", 32'(reg_data), 32'hA001);
        tick();
        check("fc2_ack", 32'(ack), 32'h4);  check("fc2_en", 32'(reg_en), 32'h04); check("fc2_data", 32'(reg_data), 32'hA002);
        tick();
        check("fc3_ack", 32'(ack), 32'h8);  check("fc3_en", 32'(reg_en), 32'h10); check("fc3_data", 32'(reg_data), 32'hA003);
        tick();
        check("fc4_ack", 32'(ack), 32'h1);  check("fc4_en", 32'(reg_en), 32'h01); check("fc4_busy", 32'(busy), 32'h1);
        tick();
        check("fc5_ack", 32'(ack), 32'h2);  check("fc5_en", 32'(reg_en), 32'h02);
        req = '0;

        // Same requester back to back: only req[2], addr changes after each grant
        set_req(2, 1'b1, 3'd1, 16'h2001);
        tick();
        check("b2b1_ack", 32'(ack), 32'h4); check("b2b1_en", 32'(reg_en), 32'h02);
        set_req(2, 1'b1, 3'd3, 16'h2003);
        tick();
        check("b2b2_ack", 32'(ack), 32'h0); check("b2b2_en", 32'(reg_en), 32'h00);
        tick();
        check("b2b3_ack", 32'(ack), 32'h4); check("b2b3_en", 32'(reg_en), 32'h08);
        set_req(2, 1'b1, 3'd5, 16'h2005);
        tick();
        check("b2b4_ack", 32'(ack), 32'h0); check("b2b4_en", 32'(reg_en), 32'h00);
        tick();
        check("b2b5_ack", 32'(ack), 32'h4); check("b2b5_en", 32'(reg_en), 32'h20); check("b2b5_data", 32'(reg_data), 32'h2005);
        tick();
        check("b2b6_ack", 32'(ack), 32'h0); check("b2b6_busy", 32'(busy), 32'h0);
        req = '0;

        // Out-of-range address on requester 1
        set_req(1, 1'b1, 3'd7, 16'h5555);
        tick();
        check("oor_ack",  32'(ack), 32'h2);
        check("oor_en",   32'(reg_en), 32'h0);
        check("oor_err",  32'(addr_err), 32'h1);
        check("oor_busy", 32'(busy), 32'h1);
        req = '0;
        tick();
        check("oor_err_pulse", 32'(addr_err), 32'h0);
        check("bank0", 32'(bank[0]), 32'hA000);
        check("bank1", 32'(bank[1]), 32'h2001);
        check("bank2", 32'(bank[2]), 32'hA002);
        check("bank3", 32'(bank[3]), 32'h2003);
        check("bank4", 32'(bank[4]), 32'hA003);
        check("bank5", 32'(bank[5]), 32'h2005);

        // Pointer fairness: grant 3, then req=1001 alternates 0,3,0,3
        set_req(3, 1'b1, 3'd4, 16'h3003);
        tick();
        check("pf_ack3", 32'(ack), 32'h8);
        set_req(0, 1'b1, 3'd0, 16'h3000);
        tick();
        check("pf_a", 32'(ack), 32'h1);
        tick();
        check("pf_b", 32'(ack), 32'h8);
        tick();
        check("pf_c", 32'(ack), 32'h1);
        tick();
        check("pf_d", 32'(ack), 32'h8);
        req = '0;
        tick();
        check("final_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
